// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and default sizing for the round-robin slot
//               arbiter (FSM state encoding, default requester count and
//               default slot length).
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Arbiter FSM states; one bit is enough for the two-state machine.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Default number of requesters.
    localparam int ARB_N_DEFAULT    = 4;

    // Default maximum BUSY cycles per grant when the slot timeout is built in.
    localparam int ARB_SLOT_DEFAULT = 6;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating first-set search. Starting at index
//               ptr and moving upward modulo N, returns the first requester
//               whose req bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Candidate index; one extra bit so ptr+k cannot overflow before the
    // modulo-N fold.
    logic [W:0] w_sum;
    logic [W-1:0] w_cand;

    // Walk the N candidates in priority order (ptr, ptr+1, ...); the first
    // hit wins and later hits are ignored through the found flag.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, ptr} + (W+1)'(k);
            if (w_sum >= (W+1)'(N)) begin
                w_sum = w_sum - (W+1)'(N);
            end
            w_cand = w_sum[W-1:0];
            if (!found && req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_slot_arbiter
// Description : Round-robin arbiter for N level requesters. A grant is held
//               while its request stays high and released with a mandatory
//               grant-free gap cycle; priority rotates past the last owner.
//               Optional slot timeout (macro ARB_SLOT_TIMEOUT_EN) forces a
//               release after SLOT BUSY cycles and pulses timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_slot_arbiter
    import arb_pkg::*;
#(
    parameter int N    = ARB_N_DEFAULT,
    parameter int SLOT = ARB_SLOT_DEFAULT,
    localparam int W   = $clog2(N),
    localparam int SW  = $clog2(SLOT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_id,
    output logic         busy,
    output logic         timeout
);

    localparam logic [N-1:0]  c_one       = N'(1);
    localparam logic [W-1:0]  c_last_id   = W'(N - 1);
    localparam logic [SW-1:0] c_slot_last = SW'(SLOT - 1);

    arb_state_t   r_state;
    arb_state_t   w_state_nxt;
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_ptr_nxt;
    logic [N-1:0] r_grant;
    logic [N-1:0] w_grant_nxt;
    logic [W-1:0] r_grant_id;
    logic [W-1:0] w_grant_id_nxt;

    logic         w_found;
    logic [W-1:0] w_pick_idx;
    logic [W-1:0] w_ptr_inc;

    // Rotating search over the live requests, starting at the pointer.
    rr_pick #(
        .N (N)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    // Next pointer on release: one past the current owner, wrapping at N.
    assign w_ptr_inc = (r_grant_id == c_last_id) ? '0 : (r_grant_id + W'(1));

`ifdef ARB_SLOT_TIMEOUT_EN
    logic [SW-1:0] r_slot;
    logic [SW-1:0] w_slot_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;
`else
    // Slot sizing has no hardware without the timeout; keep it referenced.
    logic w_unused_cfg;
    assign w_unused_cfg = ^c_slot_last;
`endif

    // Next-state and next-output decode; everything holds while en is low.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
`ifdef ARB_SLOT_TIMEOUT_EN
        w_slot_nxt     = r_slot;
        w_timeout_nxt  = 1'b0;
`endif
        if (en) begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        w_state_nxt    = BUSY;
                        w_grant_nxt    = c_one << w_pick_idx;
                        w_grant_id_nxt = w_pick_idx;
`ifdef ARB_SLOT_TIMEOUT_EN
                        w_slot_nxt     = '0;
`endif
                    end else begin
                        w_grant_nxt    = '0;
                        w_grant_id_nxt = '0;
                    end
                end
                BUSY: begin
                    // Only the owner's request matters while BUSY.
                    if (!req[r_grant_id]) begin
                        w_state_nxt    = IDLE;
                        w_grant_nxt    = '0;
                        w_grant_id_nxt = '0;
                        w_ptr_nxt      = w_ptr_inc;
`ifdef ARB_SLOT_TIMEOUT_EN
                    end else if (r_slot == c_slot_last) begin
                        // Owner overstayed its slot: forced release.
                        w_state_nxt    = IDLE;
                        w_grant_nxt    = '0;
                        w_grant_id_nxt = '0;
                        w_ptr_nxt      = w_ptr_inc;
                        w_timeout_nxt  = 1'b1;
                    end else begin
                        w_slot_nxt     = r_slot + SW'(1);
`endif
                    end
                end
                default: begin
                    w_state_nxt    = IDLE;
                    w_grant_nxt    = '0;
                    w_grant_id_nxt = '0;
                end
            endcase
        end
    end

    // State register; synchronous active-low reset overrides en.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
        end
    end

`ifdef ARB_SLOT_TIMEOUT_EN
    // Slot counter and timeout pulse register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_slot    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_slot    <= w_slot_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Gate with en so the pulse is never seen while the block is frozen.
    assign timeout = r_timeout & en;
`else
    assign timeout = 1'b0;
`endif

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == BUSY);

endmodule : rr_slot_arbiter
`default_nettype wire
